// File: rtl/vm_vend_ctrl.sv
// -----------------------------------------------------------------------------
// vm_vend_ctrl -- vending machine controller
//
// Keeps a cents balance (0..100, multiple of 5) from inserted coins. It vends
// items priced (item+1)*10 cents, then returns change one coin per cycle,
// largest first. A refund request returns the whole balance as change.
//
// Ports
//   clk         in   system clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset
//   coin[1:0]   in   coin this cycle: 00 none, 01 5c, 10 10c, 11 25c
//   item[1:0]   in   item code for a purchase request
//   item_valid  in   one-cycle purchase request
//   refund      in   one-cycle request to return the full balance
//   dollars[7:0] out balance / 100 (0 or 1)
//   cents[7:0]  out  balance % 100
//   disp_item   out  item being dispensed, meaningful while green=1
//   green       out  dispense strobe (VEND state)
//   blue        out  busy: VEND or CHANGE
//   red         out  registered one-cycle error pulse
//   chg_valid   out  one change coin is returned this cycle
//   chg_coin    out  code of the returned change coin
// -----------------------------------------------------------------------------
module vm_vend_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] coin,
   input  logic [1:0] item,
   input  logic       item_valid,
   input  logic       refund,
   output logic [7:0] dollars,
   output logic [7:0] cents,
   output logic [1:0] disp_item,
   output logic       green,
   output logic       blue,
   output logic       red,
   output logic       chg_valid,
   output logic [1:0] chg_coin
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CREDIT = 2'd1,
      S_VEND   = 2'd2,
      S_CHANGE = 2'd3
   } state_t;

   localparam logic [7:0] MAX_BAL = 8'd100;

   state_t     state_q, state_d;
   logic [7:0] bal_q, bal_d;
   logic       red_q, red_d;
   logic [1:0] disp_item_q, disp_item_d;

   logic [7:0] coin_val;
   logic [7:0] coin_sum;
   logic       coin_fits;
   logic [7:0] price;
   logic [7:0] chg_val;
   logic [1:0] chg_code;

   // Value of the presented coin in cents.
   always_comb begin
      unique case (coin)
         2'b01:   coin_val = 8'd5;
         2'b10:   coin_val = 8'd10;
         2'b11:   coin_val = 8'd25;
         default: coin_val = 8'd0;
      endcase
   end

   // Balance never exceeds 100 and a coin is at most 25, so the sum fits 8 bits.
   assign coin_sum  = bal_q + coin_val;
   assign coin_fits = (coin_sum <= MAX_BAL);
   assign price     = ({6'd0, item} + 8'd1) * 8'd10;

   // Largest change coin not exceeding the balance.
   always_comb begin
      if (bal_q >= 8'd25) begin
         chg_val  = 8'd25;
         chg_code = 2'b11;
      end else if (bal_q >= 8'd10) begin
         chg_val  = 8'd10;
         chg_code = 2'b10;
      end else if (bal_q >= 8'd5) begin
         chg_val  = 8'd5;
         chg_code = 2'b01;
      end else begin
         chg_val  = 8'd0;
         chg_code = 2'b00;
      end
   end

   // State register. Reset overrides every input in the same edge, so an
   // interrupted vend or change sequence simply forfeits the remaining balance.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= S_IDLE;
         bal_q       <= 8'd0;
         red_q       <= 1'b0;
         disp_item_q <= 2'b00;
      end else begin
         state_q     <= state_d;
         bal_q       <= bal_d;
         red_q       <= red_d;
         disp_item_q <= disp_item_d;
      end
   end

   // Next-state and balance logic.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can
      // leave it unassigned and infer a latch.
      state_d     = state_q;
      bal_d       = bal_q;
      red_d       = 1'b0;
      disp_item_d = disp_item_q;

      unique case (state_q)
         S_IDLE, S_CREDIT: begin
            // A coin is applied first; refund then sees the updated balance.
            if (coin != 2'b00) begin
               if (coin_fits) bal_d = coin_sum;
               else           red_d = 1'b1;
            end

            if (refund && (state_q == S_CREDIT)) begin
               // Balance is non-zero in CREDIT, so there is change to return.
               state_d = S_CHANGE;
            end else if (coin != 2'b00) begin
               // A coinciding purchase request is ignored in favour of the coin.
               if (bal_d != 8'd0) state_d = S_CREDIT;
            end else if (item_valid) begin
               if ((state_q == S_CREDIT) && (bal_q >= price)) begin
                  bal_d       = bal_q - price;
                  disp_item_d = item;
                  state_d     = S_VEND;
               end else begin
                  red_d = 1'b1;
               end
            end
         end

         S_VEND: begin
            if (coin != 2'b00) red_d = 1'b1;
            state_d = (bal_q != 8'd0) ? S_CHANGE : S_IDLE;
         end

         S_CHANGE: begin
            if (coin != 2'b00) red_d = 1'b1;
            bal_d = bal_q - chg_val;
            if (bal_d == 8'd0) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Moore outputs decoded from registered state and balance.
   always_comb begin
      green     = (state_q == S_VEND);
      blue      = (state_q == S_VEND) || (state_q == S_CHANGE);
      chg_valid = (state_q == S_CHANGE);
      chg_coin  = (state_q == S_CHANGE) ? chg_code : 2'b00;
      if (bal_q >= MAX_BAL) begin
         dollars = 8'd1;
         cents   = bal_q - MAX_BAL;
      end else begin
         dollars = 8'd0;
         cents   = bal_q;
      end
   end

   assign red       = red_q;
   assign disp_item = disp_item_q;

endmodule

// File: tb/tb_vm_vend_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vm_vend_ctrl -- self-checking bench for vm_vend_ctrl
//
// A table of {inputs, expected outputs after the edge} records is driven one
// per cycle; each expected record is queued when its stimulus is applied and
// popped for comparison once the DUT has clocked it. A hand-written sequence
// then checks a full 100c refund against a queue of expected change coins.
// -----------------------------------------------------------------------------
module tb_vm_vend_ctrl;

   logic       clk;
   logic       rst;
   logic [1:0] coin;
   logic [1:0] item;
   logic       item_valid;
   logic       refund;
   logic [7:0] dollars;
   logic [7:0] cents;
   logic [1:0] disp_item;
   logic       green;
   logic       blue;
   logic       red;
   logic       chg_valid;
   logic [1:0] chg_coin;

   int checks   = 0;
   int failures = 0;

   vm_vend_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .coin       (coin),
      .item       (item),
      .item_valid (item_valid),
      .refund     (refund),
      .dollars    (dollars),
      .cents      (cents),
      .disp_item  (disp_item),
      .green      (green),
      .blue       (blue),
      .red        (red),
      .chg_valid  (chg_valid),
      .chg_coin   (chg_coin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case anything hangs.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       rst;
      logic [1:0] coin;
      logic [1:0] item;
      logic       iv;
      logic       rf;
      logic [7:0] dol;
      logic [7:0] cen;
      logic [1:0] disp;
      logic       grn;
      logic       blu;
      logic       red;
      logic       cv;
      logic [1:0] cc;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   logic [1:0] chg_q[$];

   function automatic vec_t mk(
      input logic r, input logic [1:0] c, input logic [1:0] it, input logic iv, input logic rf,
      input logic [7:0] dol, input logic [7:0] cen, input logic [1:0] disp,
      input logic grn, input logic blu, input logic rd, input logic cv, input logic [1:0] cc);
      vec_t v;
      v.rst = r;   v.coin = c;   v.item = it;  v.iv = iv;  v.rf = rf;
      v.dol = dol; v.cen = cen;  v.disp = disp;
      v.grn = grn; v.blu = blu;  v.red = rd;   v.cv = cv;  v.cc = cc;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s (step %0d): got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] c, input logic [1:0] it,
                        input logic iv, input logic rf);
      @(negedge clk);
      rst = r; coin = c; item = it; item_valid = iv; refund = rf;
   endtask

   initial begin
      rst = 1'b1; coin = 2'b00; item = 2'b00; item_valid = 1'b0; refund = 1'b0;

      // Columns: rst coin item iv rf | dollars cents disp green blue red chg_valid chg_coin
      // Reset overrides inputs; two reset cycles, everything zero.
      vecs.push_back(mk(1, 2'b11, 2'd1, 1, 1,  0,   0, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(1, 2'b00, 2'd0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 2'b00));
      // 25 + 10, buy item 2 (30c) -> vend, 5c change, idle.
      vecs.push_back(mk(0, 2'b11, 2'd0, 0, 0,  0,  25, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b10, 2'd0, 0, 0,  0,  35, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b00, 2'd2, 1, 0,  0,   5, 2, 1, 1, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,   5, 0, 0, 1, 0, 1, 2'b01));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 2'b00));
      // 10c, item 3 (40c) -> insufficient: single red pulse, balance kept; refund.
      vecs.push_back(mk(0, 2'b10, 2'd0, 0, 0,  0,  10, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b00, 2'd3, 1, 0,  0,  10, 0, 0, 0, 1, 0, 2'b00));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,  10, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 1,  0,  10, 0, 0, 1, 0, 1, 2'b10));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 2'b00));
      // Four 25c -> 1.00; fifth 25c and a 5c rejected with consecutive red pulses.
      vecs.push_back(mk(0, 2'b11, 2'd0, 0, 0,  0,  25, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b11, 2'd0, 0, 0,  0,  50, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b11, 2'd0, 0, 0,  0,  75, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b11, 2'd0, 0, 0,  1,   0, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b11, 2'd0, 0, 0,  1,   0, 0, 0, 0, 1, 0, 2'b00));
      vecs.push_back(mk(0, 2'b01, 2'd0, 0, 0,  1,   0, 0, 0, 0, 1, 0, 2'b00));
      // Buy item 3 (40c) from 100 -> 60c change; coin during VEND rejected,
      // purchase/refund during CHANGE ignored.
      vecs.push_back(mk(0, 2'b00, 2'd3, 1, 0,  0,  60, 3, 1, 1, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b01, 2'd0, 0, 0,  0,  60, 0, 0, 1, 1, 1, 2'b11));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,  35, 0, 0, 1, 0, 1, 2'b11));
      vecs.push_back(mk(0, 2'b00, 2'd0, 1, 1,  0,  10, 0, 0, 1, 0, 1, 2'b10));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 2'b00));
      // 45c then refund -> 25, 10, 10 then idle.
      vecs.push_back(mk(0, 2'b11, 2'd0, 0, 0,  0,  25, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b10, 2'd0, 0, 0,  0,  35, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b10, 2'd0, 0, 0,  0,  45, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 1,  0,  45, 0, 0, 1, 0, 1, 2'b11));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,  20, 0, 0, 1, 0, 1, 2'b10));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,  10, 0, 0, 1, 0, 1, 2'b10));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 2'b00));
      // 45c refund, reset during the first CHANGE cycle -> change forfeited.
      vecs.push_back(mk(0, 2'b11, 2'd0, 0, 0,  0,  25, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b10, 2'd0, 0, 0,  0,  35, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b10, 2'd0, 0, 0,  0,  45, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 1,  0,  45, 0, 0, 1, 0, 1, 2'b11));
      vecs.push_back(mk(1, 2'b00, 2'd0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 2'b00));
      // Coin with item_valid: coin wins, no red. Refund with coin: coin added first.
      vecs.push_back(mk(0, 2'b10, 2'd0, 1, 0,  0,  10, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b01, 2'd0, 0, 1,  0,  15, 0, 0, 1, 0, 1, 2'b10));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,   5, 0, 0, 1, 0, 1, 2'b01));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 2'b00));
      // Refund in IDLE ignored; purchase in IDLE is an error.
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 1,  0,   0, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b00, 2'd0, 1, 0,  0,   0, 0, 0, 0, 1, 0, 2'b00));
      // Refund and item_valid together: refund only (no red although 5c < 10c).
      vecs.push_back(mk(0, 2'b01, 2'd0, 0, 0,  0,   5, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b00, 2'd0, 1, 1,  0,   5, 0, 0, 1, 0, 1, 2'b01));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 2'b00));
      // Exact price: vend leaves zero balance and returns straight to idle.
      vecs.push_back(mk(0, 2'b10, 2'd0, 0, 0,  0,  10, 0, 0, 0, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b00, 2'd0, 1, 0,  0,   0, 0, 1, 1, 0, 0, 2'b00));
      vecs.push_back(mk(0, 2'b00, 2'd0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 2'b00));

      foreach (vecs[i]) begin
         vec_t e;
         drive(vecs[i].rst, vecs[i].coin, vecs[i].item, vecs[i].iv, vecs[i].rf);
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check("dollars",   i, dollars,          e.dol);
         check("cents",     i, cents,            e.cen);
         check("green",     i, {7'd0, green},    {7'd0, e.grn});
         check("blue",      i, {7'd0, blue},     {7'd0, e.blu});
         check("red",       i, {7'd0, red},      {7'd0, e.red});
         check("chg_valid", i, {7'd0, chg_valid}, {7'd0, e.cv});
         check("chg_coin",  i, {6'd0, chg_coin}, {6'd0, e.cc});
         if (e.grn) check("disp_item", i, {6'd0, disp_item}, {6'd0, e.disp});
      end

      // Full 1.00 refund: expect exactly four 25c coins, then idle, within a budget.
      begin
         int sum  = 0;
         bit done = 1'b0;
         for (int k = 0; k < 4; k++) drive(1'b0, 2'b11, 2'd0, 1'b0, 1'b0);
         drive(1'b0, 2'b00, 2'd0, 1'b0, 1'b1);
         for (int k = 0; k < 4; k++) chg_q.push_back(2'b11);
         @(posedge clk);
         #1;
         drive(1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
         for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (chg_valid) begin
               if (chg_q.size() == 0) begin
                  check("extra_chg_coin", 1000 + cyc, {6'd0, chg_coin}, 8'd0);
               end else begin
                  logic [1:0] exp_c;
                  exp_c = chg_q.pop_front();
                  check("refund100_coin", 1000 + cyc, {6'd0, chg_coin}, {6'd0, exp_c});
               end
               sum += (chg_coin == 2'b11) ? 25 : (chg_coin == 2'b10) ? 10 :
                      (chg_coin == 2'b01) ? 5 : 0;
            end else if (!blue) begin
               done = 1'b1;
            end
            if (!done) begin
               @(posedge clk);
               #1;
            end
         end
         check("refund100_done", 2000, {7'd0, done}, 8'd1);
         check("refund100_sum",  2001, sum[7:0], 8'd100);
         check("refund100_left", 2002, chg_q.size(), 8'd0);
         check("refund100_cents", 2003, cents, 8'd0);
         check("refund100_dollars", 2004, dollars, 8'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vm_vend_ctrl.md
VM_VEND_CTRL -- requirements
Module: vm_vend_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: coin  in  2  coin this cycle: 00 none, 01 5c, 10 10c, 11 25c.
REQ-004 SHALL have ports: item  in  2  item code; price = (item+1)*10 cents (10/20/30/40).
REQ-005 SHALL have ports: item_valid  in  1  one-cycle purchase request for item.
REQ-006 SHALL have ports: refund  in  1  one-cycle request to return full balance.
REQ-007 SHALL have ports: dollars  out  8  balance / 100.
REQ-008 SHALL have ports: cents  out  8  balance % 100.
REQ-009 SHALL have ports: disp_item  out  2  item being dispensed; valid while green=1.
REQ-010 SHALL have ports: green  out  1  dispense strobe.
REQ-011 SHALL have ports: blue  out  1  busy (vending or returning change).
REQ-012 SHALL have ports: red  out  1  one-cycle error pulse.
REQ-013 SHALL have ports: chg_valid  out  1  one change coin returned this cycle.
REQ-014 SHALL have ports: chg_coin  out  2  change coin code, same encoding as coin.

Function
REQ-015 SHALL hold balance in an 8-bit cents register, always a multiple of 5, range 0..100.
REQ-016 SHALL implement FSM states IDLE, CREDIT, VEND, CHANGE; IDLE iff balance=0 and not busy.
REQ-017 SHALL, in IDLE/CREDIT, add an accepted coin to balance on the edge it is presented, entering CREDIT.
REQ-018 SHALL reject a coin that would make balance exceed 100: balance unchanged, red=1 the next cycle.
REQ-019 SHALL, in CREDIT on item_valid with balance >= price and no coin that cycle, subtract price and enter VEND next cycle.
REQ-020 SHALL, on item_valid with balance < price, keep balance and state, red=1 the next cycle.
REQ-021 SHALL, when coin!=00 and item_valid coincide, accept the coin and ignore item_valid (no red).
REQ-022 SHALL, when refund and item_valid coincide, honour refund only; refund in IDLE is ignored.
REQ-023 SHALL, on refund in CREDIT with any accepted coin that cycle added first, enter CHANGE next cycle.
REQ-024 SHALL hold VEND exactly one cycle: green=1, disp_item=latched item; then CHANGE if balance>0 else IDLE.
REQ-025 SHALL, each CHANGE cycle, drive chg_valid=1, chg_coin=largest of 25/10/5 not exceeding balance, and subtract it at that edge.
REQ-026 SHALL leave CHANGE for IDLE on the edge where balance becomes 0.
REQ-027 SHALL, in VEND/CHANGE, reject nonzero coin (red next cycle, balance unaffected by it) and ignore item_valid/refund.
REQ-028 SHALL drive blue=1 iff state is VEND or CHANGE; green, chg_valid, blue decoded from registered state (Moore).
REQ-029 SHALL derive dollars/cents combinationally from the balance register (dollars is 0 or 1).
REQ-030 SHALL make red a registered single-cycle pulse; errors in consecutive cycles give consecutive pulses.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set state=IDLE, balance=0, red=0, disp_item=00, overriding all inputs.
REQ-032 SHALL therefore output dollars=0, cents=0, green=0, blue=0, chg_valid=0, chg_coin=00 after reset, including reset mid-VEND/CHANGE (remaining change forfeited).

Verification
REQ-033 SHALL cover: rst 2 cycles -> all outputs 0, chg_valid never asserts.
REQ-034 SHALL cover: coins 25,10 then item=2 -> next cycle green=1 disp_item=2 blue=1; next chg_valid=1 chg_coin=01; then IDLE, cents=0.
REQ-035 SHALL cover: coin 10 then item=3 -> red=1 one cycle, cents=10, no green.
REQ-036 SHALL cover: four 25c coins -> dollars=1 cents=0; fifth 25c -> red=1, balance stays 100.
REQ-037 SHALL cover: 45c then refund -> chg_coin 11,10,10 on three consecutive cycles, then IDLE, blue=0.
REQ-038 SHALL cover: rst asserted during first CHANGE cycle of 45c refund -> next cycle balance 0, chg_valid=0, blue=0.
